// File: rtl/chart_sequencer.sv
// -----------------------------------------------------------------------------
// chart_sequencer
//   Plays a step chart. Rows of 5 bits are fetched from a synchronous chart
//   ROM, and one row of lane-spawn bits is emitted per tempo beat. Chart
//   timing advances only on rising edges of the vsync-rate frame tick.
//   This block owns the song state: idle, fetch, play, pause, drain and done.
//
// Ports
//   Clk            in   1       system clock
//   reset_n        in   1       asynchronous active-low reset
//   frame_clk      in   1       vsync-rate tick; its rising edge is detected on Clk
//   start          in   1       begin song from row 0 (honoured in IDLE/DONE only)
//   pause          in   1       level; freezes chart progress while high
//   rom_addr       out  ADDR_W  chart ROM row address
//   rom_data       in   5       ROM row: [4]=end marker, [3:0]=lanes 0..3
//   display_signal out  4       lane spawn bits, held for one full frame
//   playing        out  1       high in PLAY and PAUSE
//   song_done      out  1       high in DONE
//   row_index      out  ADDR_W  index of the last emitted row
// -----------------------------------------------------------------------------
module chart_sequencer #(
    parameter int ADDR_W         = 12,
    parameter int FRAMES_PER_ROW = 8,
    parameter int DRAIN_FRAMES   = 240
) (
    input  logic              Clk,
    input  logic              reset_n,
    input  logic              frame_clk,
    input  logic              start,
    input  logic              pause,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [4:0]        rom_data,
    output logic [3:0]        display_signal,
    output logic              playing,
    output logic              song_done,
    output logic [ADDR_W-1:0] row_index
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_PLAY  = 3'd2;
    localparam logic [2:0] S_PAUSE = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [7:0]  BEAT_LAST  = 8'(FRAMES_PER_ROW - 1);
    localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_FRAMES - 1);

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic              r_frame_d;
    logic              w_fedge;
    logic [7:0]        r_beat_cnt;
    logic [15:0]       r_drain_cnt;
    logic [4:0]        r_row_buf;
    logic [1:0]        r_ld;
    logic [ADDR_W-1:0] r_rom_addr;
    logic [ADDR_W-1:0] r_row_index;
    logic [3:0]        r_disp;
    logic              r_playing;
    logic              r_song_done;
    logic              w_beat_end;
    logic              w_chart_end;
    logic              w_advance;
    logic              w_emit;
    logic              w_fetch_go;

    assign w_fedge     = frame_clk & ~r_frame_d;
    assign w_beat_end  = (r_beat_cnt == BEAT_LAST);
    // The last ROM address is never emitted, so rom_addr cannot wrap to 0.
    assign w_chart_end = r_row_buf[4] | (r_rom_addr == {ADDR_W{1'b1}});
    assign w_advance   = (r_state == S_PLAY) & w_fedge & ~pause;
    assign w_emit      = w_advance & w_beat_end & ~w_chart_end;
    assign w_fetch_go  = start & ((r_state == S_IDLE) | (r_state == S_DONE));

    assign rom_addr       = r_rom_addr;
    assign row_index      = r_row_index;
    assign display_signal = r_disp;
    assign playing        = r_playing;
    assign song_done      = r_song_done;

    // Song state transitions.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_FETCH;
                else       w_state_nxt = S_IDLE;
            end
            S_FETCH: begin
                if (r_ld[1]) w_state_nxt = S_PLAY;
                else         w_state_nxt = S_FETCH;
            end
            S_PLAY: begin
                if (w_fedge && pause)                   w_state_nxt = S_PAUSE;
                else if (w_advance && w_beat_end && w_chart_end) w_state_nxt = S_DRAIN;
                else                                    w_state_nxt = S_PLAY;
            end
            S_PAUSE: begin
                if (w_fedge && !pause) w_state_nxt = S_PLAY;
                else                   w_state_nxt = S_PAUSE;
            end
            S_DRAIN: begin
                if (w_fedge && (r_drain_cnt == DRAIN_LAST)) w_state_nxt = S_DONE;
                else                                        w_state_nxt = S_DRAIN;
            end
            S_DONE: begin
                if (start) w_state_nxt = S_FETCH;
                else       w_state_nxt = S_DONE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register plus status flags registered from the next state.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_playing   <= 1'b0;
            r_song_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_playing   <= (w_state_nxt == S_PLAY) | (w_state_nxt == S_PAUSE);
            r_song_done <= (w_state_nxt == S_DONE);
        end
    end

    // Frame-edge delay and ROM access: r_ld marks the cycle when rom_data
    // reflects the address issued two edges earlier.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            r_frame_d   <= 1'b0;
            r_ld        <= 2'b00;
            r_rom_addr  <= {ADDR_W{1'b0}};
            r_row_index <= {ADDR_W{1'b0}};
            r_row_buf   <= 5'd0;
        end else begin
            r_frame_d <= frame_clk;
            if (w_fetch_go || w_emit) r_ld <= 2'b01;
            else                      r_ld <= {r_ld[0], 1'b0};
            if (w_fetch_go) begin
                r_rom_addr  <= {ADDR_W{1'b0}};
                r_row_index <= {ADDR_W{1'b0}};
            end else if (w_emit) begin
                r_rom_addr  <= r_rom_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
                r_row_index <= r_rom_addr;
            end
            if (r_ld[1]) r_row_buf <= rom_data;
        end
    end

    // Beat and drain counters plus the registered lane output.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            r_beat_cnt  <= 8'd0;
            r_drain_cnt <= 16'd0;
            r_disp      <= 4'd0;
        end else begin
            if ((r_state == S_FETCH) && r_ld[1]) begin
                r_beat_cnt <= BEAT_LAST;
            end else if (w_advance) begin
                if (w_beat_end) r_beat_cnt <= 8'd0;
                else            r_beat_cnt <= r_beat_cnt + 8'd1;
            end
            if (w_advance && w_beat_end && w_chart_end) r_drain_cnt <= 16'd0;
            else if ((r_state == S_DRAIN) && w_fedge)   r_drain_cnt <= r_drain_cnt + 16'd1;
            // Lanes are presented only on an emitting fedge; every other fedge clears them.
            if (w_fedge) begin
                if (w_emit) r_disp <= r_row_buf[3:0];
                else        r_disp <= 4'd0;
            end
        end
    end

endmodule
